// File: rtl/contador_bounce.sv
// Up/down counter with programmable bounds: wrap-up, wrap-down, bounce with endpoint dwell, hold.
// Successor of the fixed 4-bit ping-pong counter; used as a sequencer or address sweeper.
module contador_bounce #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   lim_min,
  input  logic [WIDTH-1:0]   lim_max,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  output logic [WIDTH-1:0]   c,
  output logic               direcao,
  output logic               at_limit,
  output logic               turn,
  output logic               err
);

  typedef enum logic [1:0] {
    ModeUp     = 2'b00,
    ModeDown   = 2'b01,
    ModeBounce = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]   One    = WIDTH'(1);
  localparam logic [DWELL_W-1:0] DwOne  = DWELL_W'(1);

  logic [WIDTH-1:0]   c_q, c_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwc_q, dwc_d;
  logic               turn_q, turn_d;
  mode_e              mode_s;
  logic               step_en, out_of_range, count_up;

  assign mode_s       = mode_e'(mode);
  assign err          = lim_min > lim_max;
  assign at_limit     = (c_q == lim_min) || (c_q == lim_max);
  assign step_en      = enable && !err && (mode_s != ModeHold);
  assign out_of_range = (c_q < lim_min) || (c_q > lim_max);
  // Direction used for out-of-range recovery follows the mode, not only direcao.
  assign count_up     = (mode_s == ModeUp) || ((mode_s == ModeBounce) && !dir_q);

  always_comb begin
    c_d    = c_q;
    dir_d  = dir_q;
    dwc_d  = dwc_q;
    turn_d = 1'b0;
    if (load) begin
      c_d   = load_value;
      dwc_d = '0;
    end else if (step_en) begin
      if (mode_s != ModeBounce) dwc_d = '0;
      if (out_of_range) begin
        c_d   = count_up ? lim_min : lim_max;
        dwc_d = '0;
      end else if (lim_min == lim_max) begin
        c_d = lim_min;
      end else begin
        case (mode_s)
          ModeUp: begin
            dir_d = 1'b0;
            if (c_q < lim_max) begin
              c_d = c_q + One;
            end else begin
              c_d    = lim_min;
              turn_d = 1'b1;
            end
          end
          ModeDown: begin
            dir_d = 1'b1;
            if (c_q > lim_min) begin
              c_d = c_q - One;
            end else begin
              c_d    = lim_max;
              turn_d = 1'b1;
            end
          end
          ModeBounce: begin
            if (!dir_q) begin
              if (c_q != lim_max) begin
                c_d = c_q + One;
              end else if (dwc_q < dwell) begin
                dwc_d = dwc_q + DwOne;
              end else begin
                dir_d  = 1'b1;
                c_d    = c_q - One;
                dwc_d  = '0;
                turn_d = 1'b1;
              end
            end else begin
              if (c_q != lim_min) begin
                c_d = c_q - One;
              end else if (dwc_q < dwell) begin
                dwc_d = dwc_q + DwOne;
              end else begin
                dir_d  = 1'b0;
                c_d    = c_q + One;
                dwc_d  = '0;
                turn_d = 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_q    <= '0;
      dir_q  <= 1'b0;
      dwc_q  <= '0;
      turn_q <= 1'b0;
    end else begin
      c_q    <= c_d;
      dir_q  <= dir_d;
      dwc_q  <= dwc_d;
      turn_q <= turn_d;
    end
  end

  assign c       = c_q;
  assign direcao = dir_q;
  assign turn    = turn_q;

endmodule

// File: tb/tb_contador_bounce.sv
// Scoreboarded bench for contador_bounce: directed scenarios plus randomized traffic
// checked against a behavioural model of the counting rules.
module tb_contador_bounce;

  localparam int W  = 4;
  localparam int DW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  lim_min = '0;
  logic [W-1:0]  lim_max = '0;
  logic [DW-1:0] dwell = '0;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic [W-1:0]  c;
  logic          direcao, at_limit, turn, err;

  contador_bounce #(.WIDTH(W), .DWELL_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .lim_min    (lim_min),
    .lim_max    (lim_max),
    .dwell      (dwell),
    .load       (load),
    .load_value (load_value),
    .c          (c),
    .direcao    (direcao),
    .at_limit   (at_limit),
    .turn       (turn),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int c;
    int dir;
    int turn;
    int atl;
    int err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: plain integers, no modular arithmetic needed inside the bounds.
  int m_c = 0, m_dir = 0, m_dw = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model(input int en, input int md, input int lmin, input int lmax,
                       input int dwl, input int ld, input int lv, output int t);
    t = 0;
    if (ld != 0) begin
      m_c = lv;
      m_dw = 0;
    end else if (lmin > lmax || en == 0 || md == 3) begin
      t = 0;
    end else begin
      int up;
      up = (md == 0) ? 1 : (md == 1) ? 0 : (m_dir == 0 ? 1 : 0);
      if (md != 2) m_dw = 0;
      if (m_c < lmin || m_c > lmax) begin
        m_c = up ? lmin : lmax;
        m_dw = 0;
      end else if (lmin == lmax) begin
        m_c = lmin;
      end else if (md == 0) begin
        m_dir = 0;
        if (m_c == lmax) begin m_c = lmin; t = 1; end
        else m_c = m_c + 1;
      end else if (md == 1) begin
        m_dir = 1;
        if (m_c == lmin) begin m_c = lmax; t = 1; end
        else m_c = m_c - 1;
      end else begin
        int endpoint;
        endpoint = (m_dir == 0) ? lmax : lmin;
        if (m_c != endpoint) m_c = (m_dir == 0) ? m_c + 1 : m_c - 1;
        else if (m_dw < dwl) m_dw = m_dw + 1;
        else begin
          m_c = (m_dir == 0) ? m_c - 1 : m_c + 1;
          m_dir = 1 - m_dir;
          m_dw = 0;
          t = 1;
        end
      end
    end
  endtask

  task automatic step(input int en, input int md, input int lmin, input int lmax,
                      input int dwl, input int ld, input int lv);
    exp_t e;
    int t;
    @(negedge clock);
    enable = en[0];
    mode = md[1:0];
    lim_min = W'(lmin);
    lim_max = W'(lmax);
    dwell = DW'(dwl);
    load = ld[0];
    load_value = W'(lv);
    model(en, md, lmin, lmax, dwl, ld, lv, t);
    e.c = m_c;
    e.dir = m_dir;
    e.turn = t;
    e.atl = (m_c == lmin || m_c == lmax) ? 1 : 0;
    e.err = (lmin > lmax) ? 1 : 0;
    q.push_back(e);
  endtask

  // Monitor: every clock edge after a stimulus cycle presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("c", int'(c), e.c);
        check("direcao", int'(direcao), e.dir);
        check("turn", int'(turn), e.turn);
        check("at_limit", int'(at_limit), e.atl);
        check("err", int'(err), e.err);
      end
    end
  end

  initial begin
    int lo, hi, dwl, md, wait_cyc;
    #3;
    check("reset_c", int'(c), 0);
    check("reset_direcao", int'(direcao), 0);
    check("reset_turn", int'(turn), 0);
    @(negedge clock);
    reset = 1'b1;

    // Legacy ping-pong: 0..15,15,14..0,0,1...
    repeat (36) step(1, 2, 0, 15, 1, 0, 0);

    // Wrap-up 3..6 then wrap-down.
    step(1, 0, 3, 6, 0, 1, 3);
    repeat (5) step(1, 0, 3, 6, 0, 0, 0);
    repeat (6) step(1, 1, 3, 6, 0, 0, 0);

    // Bounce with dwell 3, then dwell 0.
    step(1, 2, 2, 5, 3, 1, 2);
    repeat (16) step(1, 2, 2, 5, 3, 0, 0);
    repeat (8) step(1, 2, 2, 5, 0, 0, 0);

    // Load out of range, then recovery; load beats enable.
    step(1, 2, 2, 5, 0, 1, 12);
    step(1, 2, 2, 5, 0, 0, 0);
    step(1, 0, 2, 5, 0, 1, 4);
    step(1, 0, 2, 5, 0, 0, 0);

    // Error range, degenerate range, hold mode, enable low.
    repeat (3) step(1, 2, 9, 4, 0, 0, 0);
    repeat (3) step(1, 0, 7, 7, 0, 0, 0);
    repeat (3) step(1, 3, 0, 15, 0, 0, 0);
    repeat (3) step(0, 2, 0, 15, 0, 0, 0);

    // Async reset while dwelling at 5.
    step(1, 0, 2, 5, 3, 1, 4);
    step(1, 0, 2, 5, 3, 0, 0);
    step(1, 2, 2, 5, 3, 0, 0);
    step(1, 2, 2, 5, 3, 0, 0);
    @(posedge clock);
    #2;
    enable = 1'b0;
    load = 1'b0;
    reset = 1'b0;
    #1;
    check("async_reset_c", int'(c), 0);
    check("async_reset_direcao", int'(direcao), 0);
    check("async_reset_turn", int'(turn), 0);
    m_c = 0;
    m_dir = 0;
    m_dw = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1, 2, 0, 15, 1, 0, 0);

    // Randomized traffic; limits and dwell change occasionally so sequences develop.
    lo = 2; hi = 9; dwl = 1; md = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        lo = $urandom_range(0, 15);
        hi = $urandom_range(0, 15);
        if (lo > hi && $urandom_range(0, 3) != 0) begin
          int tmp;
          tmp = lo; lo = hi; hi = tmp;
        end
      end
      if ($urandom_range(0, 29) == 0) dwl = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 3);
      step(($urandom_range(0, 7) != 0) ? 1 : 0, md, lo, hi, dwl,
           ($urandom_range(0, 39) == 0) ? 1 : 0, $urandom_range(0, 15));
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
